// File: rtl/alu_pkg.sv
// Shared definitions for the sign-magnitude arithmetic units and the
// result buffer downstream of them.
//   op_t         : opcode tag carried with every unit result
//   ST_*         : bit positions inside the 4-bit unit status word
//   fifo_state_t : occupancy state of alu_result_fifo
package alu_pkg;

   typedef enum logic [1:0] {
      OP_SUB  = 2'd0,
      OP_LT   = 2'd1,
      OP_CLR  = 2'd2,
      OP_CONV = 2'd3
   } op_t;

   localparam int ST_ERR  = 0;
   localparam int ST_NEG  = 1;
   localparam int ST_PAR  = 2;
   localparam int ST_ONES = 3;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      PARTIAL = 2'd1,
      FULL    = 2'd2
   } fifo_state_t;

endpackage

// File: rtl/alu_sat_cnt.sv
// 8-bit saturating event counter.
// Ports:
//   i_clk  : clock, rising edge
//   i_rsn  : asynchronous active-low reset, clears the count
//   i_inc  : count one event this cycle
//   o_cnt  : current count, sticks at 255
module alu_sat_cnt (
   input  logic       i_clk,
   input  logic       i_rsn,
   input  logic       i_inc,
   output logic [7:0] o_cnt
);

   logic [7:0] cnt_q;

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         cnt_q <= 8'd0;
      end else if (i_inc && (cnt_q != 8'hFF)) begin
         cnt_q <= cnt_q + 8'd1;
      end
   end

   assign o_cnt = cnt_q;

endmodule

// File: rtl/alu_result_fifo.sv
// Registered output stage behind the sign-magnitude arithmetic units.
// Buffers {opcode, result, status} triples in order, 2**n entries deep,
// zeroing the result of any triple flagged as an error before storing it.
// Build option ALU_STATS_EN adds a saturating count of error results.
// Ports:
//   i_clk, i_rsn        : clock (rising edge), async active-low reset
//   i_valid / o_ready   : upstream handshake, push = i_valid && o_ready
//   i_op/i_result/i_status : incoming triple
//   o_valid / i_ready   : downstream handshake, pop = o_valid && i_ready
//   o_op/o_result/o_status : head triple, all zero while empty
//   o_count             : occupancy 0..2**n
//   o_err_cnt           : error-result count (ALU_STATS_EN only)
module alu_result_fifo
   import alu_pkg::*;
#(
   parameter int m = 4,
   parameter int n = 2
) (
   input  logic         i_clk,
   input  logic         i_rsn,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [1:0]   i_op,
   input  logic [m-1:0] i_result,
   input  logic [3:0]   i_status,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [1:0]   o_op,
   output logic [m-1:0] o_result,
   output logic [3:0]   o_status,
   output logic [n:0]   o_count
`ifdef ALU_STATS_EN
   ,
   output logic [7:0]   o_err_cnt
`endif
);

   localparam int DEPTH = 1 << n;
   localparam int EW    = 2 + m + 4;
   localparam logic [n:0]   CNT_ONE  = (n+1)'(1);
   localparam logic [n:0]   CNT_LAST = (n+1)'(DEPTH - 1);
   localparam logic [n-1:0] PTR_ONE  = n'(1);

   // Error results come out of the units undefined; store zero instead.
   function automatic logic [m-1:0] sanitise(input logic [m-1:0] res,
                                             input logic         err);
      return err ? '0 : res;
   endfunction

   logic [EW-1:0] mem [DEPTH];
   logic [n-1:0]  wptr_q, rptr_q;
   logic [n:0]    count_q;
   fifo_state_t   state_q;
   logic          push, pop;
   logic [EW-1:0] head;

   // Handshake flags are decoded from the state register only, so o_ready
   // never depends on i_ready (no pass-through when full).
   assign o_ready = (state_q != FULL);
   assign o_valid = (state_q != EMPTY);
   assign push    = i_valid && o_ready;
   assign pop     = o_valid && i_ready;

   always_ff @(posedge i_clk or negedge i_rsn) begin
      if (!i_rsn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         state_q <= EMPTY;
      end else begin
         if (push) wptr_q <= wptr_q + PTR_ONE;
         if (pop)  rptr_q <= rptr_q + PTR_ONE;
         case ({push, pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
         case (state_q)
            EMPTY: begin
               if (push) state_q <= (DEPTH == 1) ? FULL : PARTIAL;
            end
            PARTIAL: begin
               if (push && !pop && (count_q == CNT_LAST))
                  state_q <= FULL;
               else if (pop && !push && (count_q == CNT_ONE))
                  state_q <= EMPTY;
            end
            FULL: begin
               if (pop) state_q <= (DEPTH == 1) ? EMPTY : PARTIAL;
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

   // Storage carries no reset; empty masking on the outputs hides it.
   always_ff @(posedge i_clk) begin
      if (push) mem[wptr_q] <= {i_op, sanitise(i_result, i_status[ST_ERR]), i_status};
   end

   assign head = mem[rptr_q];
   assign {o_op, o_result, o_status} = o_valid ? head : '0;
   assign o_count = count_q;

`ifdef ALU_STATS_EN
   alu_sat_cnt u_err_cnt (
      .i_clk (i_clk),
      .i_rsn (i_rsn),
      .i_inc (push && i_status[ST_ERR]),
      .o_cnt (o_err_cnt)
   );
`endif

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;

   localparam int DEPTH = 4;

   logic       i_clk = 1'b0;
   logic       i_rsn;
   logic       i_valid;
   logic       o_ready;
   logic [1:0] i_op;
   logic [3:0] i_result;
   logic [3:0] i_status;
   logic       o_valid;
   logic       i_ready;
   logic [1:0] o_op;
   logic [3:0] o_result;
   logic [3:0] o_status;
   logic [2:0] o_count;
`ifdef ALU_STATS_EN
   logic [7:0] o_err_cnt;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   int exp_err = 0;
   logic [9:0] sb [$];

   always #5 i_clk = ~i_clk;

   alu_result_fifo #(.m(4), .n(2)) dut (
      .i_clk    (i_clk),
      .i_rsn    (i_rsn),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_op     (i_op),
      .i_result (i_result),
      .i_status (i_status),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_op     (o_op),
      .o_result (o_result),
      .o_status (o_status),
      .o_count  (o_count)
`ifdef ALU_STATS_EN
      ,
      .o_err_cnt(o_err_cnt)
`endif
   );

   // Scoreboard update for the current inputs, then one clock edge.
   task automatic advance();
      logic ap, aq;
      ap = i_valid && (sb.size() < DEPTH);
      aq = i_ready && (sb.size() > 0);
      if (aq) void'(sb.pop_front());
      if (ap) begin
         sb.push_back(i_status[0] ? {i_op, 4'b0000, i_status} : {i_op, i_result, i_status});
         if (i_status[0] && exp_err < 255) exp_err++;
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_reset();
      i_rsn = 1'b0;
      for (int k = 0; k < 3; k++) begin
         i_valid = 1'($urandom); i_ready = 1'($urandom);
         i_op = 2'($urandom); i_result = 4'($urandom); i_status = 4'($urandom);
         @(posedge i_clk);
         #1;
      end
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", o_valid); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", o_ready); end
      n_cmp++; if (o_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", o_count); end
      n_cmp++; if ({o_op, o_result, o_status} !== 10'd0) begin n_bad++; $display("FAIL reset_head got %h want 000", {o_op, o_result, o_status}); end
`ifdef ALU_STATS_EN
      n_cmp++; if (o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_errcnt got %0d want 0", o_err_cnt); end
`endif
      i_valid = 0; i_ready = 0; i_op = 0; i_result = 0; i_status = 0;
      i_rsn = 1'b1;
      sb.delete();
      exp_err = 0;
      @(posedge i_clk);
      #1;
   endtask

   task automatic test_fill_full();
      logic [9:0] vec [4];
      vec[0] = {2'd0, 4'b0011, 4'b0100};
      vec[1] = {2'd1, 4'b0001, 4'b0000};
      vec[2] = {2'd2, 4'b1010, 4'b0110};
      vec[3] = {2'd3, 4'b1111, 4'b1110};
      i_ready = 0;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL fill_ready%0d got %b want 1", k, o_ready); end
         i_valid = 1; {i_op, i_result, i_status} = vec[k];
         advance();
         n_cmp++; if ({o_op, o_result, o_status} !== vec[0]) begin n_bad++; $display("FAIL fill_head%0d got %h want %h", k, {o_op, o_result, o_status}, vec[0]); end
      end
      n_cmp++; if (o_count !== 3'd4) begin n_bad++; $display("FAIL full_count got %0d want 4", o_count); end
      n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL full_ready got %b want 0", o_ready); end
      i_valid = 1; i_op = 2'd1; i_result = 4'b0101; i_status = 4'b0000;
      advance();
      n_cmp++; if (o_count !== 3'd4) begin n_bad++; $display("FAIL fifth_push count got %0d want 4", o_count); end
      i_valid = 0; i_ready = 1;
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (o_valid !== 1'b1 || {o_op, o_result, o_status} !== vec[k]) begin
            n_bad++; $display("FAIL drain%0d got v=%b %h want v=1 %h", k, o_valid, {o_op, o_result, o_status}, vec[k]);
         end
         if (k == 1) begin
            n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_pop got %b want 1", o_ready); end
         end
         advance();
      end
      n_cmp++; if (o_valid !== 1'b0 || o_count !== 3'd0 || o_result !== 4'd0) begin
         n_bad++; $display("FAIL drained got v=%b cnt=%0d res=%h want v=0 cnt=0 res=0", o_valid, o_count, o_result);
      end
      i_ready = 0;
   endtask

   task automatic test_sanitise();
      i_ready = 0; i_valid = 1; i_op = 2'd0; i_result = 4'bxxxx; i_status = 4'b0001;
      advance();
      i_valid = 0; i_result = 4'b0000;
      n_cmp++; if (o_result !== 4'b0000) begin n_bad++; $display("FAIL sanitise_result got %b want 0000", o_result); end
      n_cmp++; if (o_status !== 4'b0001 || o_op !== 2'd0) begin n_bad++; $display("FAIL sanitise_tag got op=%0d st=%b want op=0 st=0001", o_op, o_status); end
`ifdef ALU_STATS_EN
      n_cmp++; if (o_err_cnt !== 8'(exp_err)) begin n_bad++; $display("FAIL errcnt got %0d want %0d", o_err_cnt, exp_err); end
`endif
      i_ready = 1;
      advance();
      i_ready = 0;
   endtask

   task automatic test_back_to_back();
      i_ready = 0;
      for (int k = 0; k < 2; k++) begin
         i_valid = 1; i_op = 2'(k + 1); i_result = 4'(4'h6 + k); i_status = 4'b0100;
         advance();
      end
      i_valid = 1; i_ready = 1; i_op = 2'd3; i_result = 4'h9; i_status = 4'b0010;
      n_cmp++; if (sb.size() == 0 || {o_op, o_result, o_status} !== sb[0]) begin n_bad++; $display("FAIL pp_head got %h want %h", {o_op, o_result, o_status}, sb.size() ? sb[0] : 10'h0); end
      advance();
      n_cmp++; if (o_count !== 3'd2) begin n_bad++; $display("FAIL pp_count got %0d want 2", o_count); end
      i_valid = 0;
      while (sb.size() > 0) begin
         n_cmp++; if ({o_op, o_result, o_status} !== sb[0]) begin n_bad++; $display("FAIL pp_order got %h want %h", {o_op, o_result, o_status}, sb[0]); end
         advance();
      end
      i_valid = 1; i_ready = 1; i_op = 2'd2; i_result = 4'hC; i_status = 4'b1000;
      n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL bypass got valid %b want 0", o_valid); end
      advance();
      i_valid = 0;
      n_cmp++; if (o_valid !== 1'b1 || {o_op, o_result, o_status} !== {2'd2, 4'hC, 4'b1000}) begin
         n_bad++; $display("FAIL latency1 got v=%b %h want v=1 %h", o_valid, {o_op, o_result, o_status}, {2'd2, 4'hC, 4'b1000});
      end
      advance();
      i_ready = 0;
   endtask

   task automatic test_wrap();
      int pushed = 0, popped = 0, cyc = 0;
      while (popped < 11 && cyc < 60) begin
         i_valid = (pushed < 11) && (cyc % 4 != 3) && (sb.size() < 3);
         i_ready = (sb.size() >= 2) || (pushed == 11);
         i_op = 2'(pushed); i_result = 4'($urandom); i_status = {3'($urandom), 1'b0};
         n_cmp++; if (o_count !== 3'(sb.size())) begin n_bad++; $display("FAIL wrap_count got %0d want %0d", o_count, sb.size()); end
         if (i_ready && sb.size() > 0) begin
            n_cmp++; if ({o_op, o_result, o_status} !== sb[0]) begin n_bad++; $display("FAIL wrap_data%0d got %h want %h", popped, {o_op, o_result, o_status}, sb[0]); end
            popped++;
         end
         if (i_valid) pushed++;
         advance();
         cyc++;
      end
      n_cmp++; if (popped != 11) begin n_bad++; $display("FAIL wrap_done got %0d want 11", popped); end
      i_valid = 0; i_ready = 0;
   endtask

   task automatic test_sat_reset();
      i_ready = 1; i_op = 2'd0; i_status = 4'b0001;
      for (int k = 0; k < 300; k++) begin
         i_valid = 1; i_result = 4'($urandom);
         advance();
      end
      i_valid = 0;
      while (sb.size() > 0) advance();
`ifdef ALU_STATS_EN
      n_cmp++; if (o_err_cnt !== 8'd255) begin n_bad++; $display("FAIL sat got %0d want 255", o_err_cnt); end
`endif
      i_ready = 0;
      for (int k = 0; k < 3; k++) begin
         i_valid = 1; i_op = 2'(k); i_result = 4'(k + 3); i_status = 4'b0000;
         advance();
      end
      i_valid = 0;
      n_cmp++; if (o_count !== 3'd3) begin n_bad++; $display("FAIL pre_rst count got %0d want 3", o_count); end
      #2 i_rsn = 0;
      #1;
      n_cmp++; if (o_count !== 3'd0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
         n_bad++; $display("FAIL async_rst got cnt=%0d v=%b r=%b want cnt=0 v=0 r=1", o_count, o_valid, o_ready);
      end
`ifdef ALU_STATS_EN
      n_cmp++; if (o_err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_errcnt got %0d want 0", o_err_cnt); end
`endif
      #1 i_rsn = 1;
      sb.delete(); exp_err = 0;
      @(posedge i_clk);
      #1;
      i_valid = 1; i_op = 2'd3; i_result = 4'hA; i_status = 4'b0010;
      advance();
      i_valid = 0;
      n_cmp++; if (o_count !== 3'd1 || {o_op, o_result, o_status} !== {2'd3, 4'hA, 4'b0010}) begin
         n_bad++; $display("FAIL post_rst got cnt=%0d %h want cnt=1 %h", o_count, {o_op, o_result, o_status}, {2'd3, 4'hA, 4'b0010});
      end
   endtask

   initial begin
      i_rsn = 0; i_valid = 0; i_ready = 0; i_op = 0; i_result = 0; i_status = 0;
      test_reset();
      test_fill_full();
      test_sanitise();
      test_back_to_back();
      test_wrap();
      test_sat_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_result_fifo.md
# alu_result_fifo

Registered output stage placed directly downstream of the sign-magnitude arithmetic units: subtract, less-than, bit-clear and sign-magnitude-to-two's-complement convert. It captures each unit's `{opcode, result, status}` triple through a valid/ready handshake and buffers up to 2**n entries in order. It sanitises error results before storage. With the statistics build option, it also keeps a saturating count of error results.

## Interface
Parameters:
- `m`, 4, data width of result (matches unit width)
- `n`, 2, log2 of buffer depth (depth = 2**n)

Ports:
- `i_clk`  in  1  clock, rising edge
- `i_rsn`  in  1  reset, asynchronous, active-low
- `i_valid`  in  1  upstream triple valid
- `o_ready`  out  1  buffer can accept
- `i_op`  in  2  opcode tag of producing unit
- `i_result`  in  m  unit result (may be X when `i_status[0]`=1)
- `i_status`  in  4  unit status: [0] error/overflow, [1] negative, [2] even parity, [3] all-ones
- `o_valid`  out  1  head entry valid
- `i_ready`  in  1  downstream accepts head
- `o_op`  out  2  head opcode
- `o_result`  out  m  head result
- `o_status`  out  4  head status
- `o_count`  out  n+1  occupancy, 0..2**n
- `o_err_cnt`  out  8  saturating error-result count (only with `ALU_STATS_EN`)

## Operation
- Push = `i_valid && o_ready`. Pop = `o_valid && i_ready`.
- `o_ready` = (`o_count` < 2**n). It is registered-state derived and has no dependence on `i_ready`. There is no pass-through when full.
- `o_valid` = (`o_count` != 0).
- Storage is a circular buffer with n-bit write and read pointers, each wrapping modulo 2**n.
- Sanitising on push: if `i_status[0]`=1, the stored result is all zeros, replacing the X from the unit. Op and status are stored unchanged. Otherwise `i_result` is stored as is.
- Empty head: `o_op`, `o_result` and `o_status` read 0, not stale memory.
- FSM state, with register `state_q`:
  - EMPTY: on push → PARTIAL (or FULL when 2**n = 1).
  - PARTIAL: push only, count reaching 2**n → FULL. Pop only, count reaching 0 → EMPTY. Push and pop together → PARTIAL, count unchanged.
  - FULL: pop → PARTIAL. `i_valid` is ignored; upstream must hold its data.
- `o_count` must always agree with the state: 0 iff EMPTY, 2**n iff FULL.
- Order is strictly FIFO.

## Timing
- Latency is 1 cycle. A triple pushed at edge k is visible on the outputs after edge k when the buffer was empty.
- `o_ready` drops in the cycle after the filling push and rises in the cycle after the first pop from FULL.
- Reset values, asserted asynchronously while `i_rsn`=0:
  - pointers, `o_count` and `o_err_cnt` = 0
  - state = EMPTY
  - `o_valid` = 0, `o_ready` = 1
  - `o_op`, `o_result`, `o_status` = 0
- Memory array is not reset. Empty masking makes its contents invisible.
- Reset asserted mid-stream discards all entries immediately. The first push after `i_rsn` rises lands in slot 0.

## Configuration
- `ALU_STATS_EN` defined:
  - `o_err_cnt` port exists.
  - It increments by 1 on every push with `i_status[0]`=1 and saturates at 255.
  - Pops do not affect it. Only reset clears it.
- `ALU_STATS_EN` undefined: port and counter logic are absent. FIFO behaviour is identical.

## Structure
- Shared package `alu_pkg`:
  - `op_t` enum: `OP_SUB`=0, `OP_LT`=1, `OP_CLR`=2, `OP_CONV`=3
  - status bit index constants: `ST_ERR`=0, `ST_NEG`=1, `ST_PAR`=2, `ST_ONES`=3
  - `fifo_state_t` enum: EMPTY, PARTIAL, FULL
- Sub-module `alu_sat_cnt`: 8-bit saturating increment counter with async active-low reset, instantiated only under `ALU_STATS_EN`.

## Test plan
- Reset: hold `i_rsn`=0 with random inputs → `o_valid`=0, `o_ready`=1, `o_count`=0, `o_result`=0, `o_status`=0, `o_err_cnt`=0.
- Fill to full: with `i_ready`=0, push 4 triples (OP_SUB/4'b0011/4'b0100, OP_LT/4'b0001/4'b0000, OP_CLR/4'b1010/4'b0110, OP_CONV/4'b1111/4'b1110) → `o_count`=4, `o_ready`=0. A fifth `i_valid` is not accepted. Then set `i_ready`=1 → the four triples drain in order.
- Error sanitise: push OP_SUB, `i_result`=4'bxxxx, `i_status`=4'b0001 → head `o_result`=4'b0000, `o_status`=4'b0001; `o_err_cnt`=1.
- Simultaneous push/pop: at `o_count`=2, push and pop in the same cycle → `o_count` stays 2 and order is preserved. From empty, push with `i_ready`=1 → data valid one cycle later, not the same cycle.
- Wrap-around: 11 interleaved push/pop pairs with occupancy 1..3 → all 11 results emerge in order across pointer wrap; the scoreboard matches.
- Saturation and mid-stream reset: 300 error pushes → `o_err_cnt`=255. Pulse `i_rsn` low while `o_count`=3 → `o_count`=0 and `o_valid`=0 immediately; the next push appears as head.
